// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants and address helpers for the 4K x 16 main data store.
//
// The 12-bit word address is split into a 3-bit bank select (upper bits)
// and a 9-bit bank offset (lower bits). The store is built from eight
// 512-word banks.
// -----------------------------------------------------------------------------
package mem_pkg;

  // Full-array geometry
  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 16;

  // Bank geometry: 8 banks of 512 words each
  localparam int BANK_ADDR_W = 9;
  localparam int NUM_BANKS   = 8;
  localparam int BANK_SEL_W  = RAM_ADDR_W - BANK_ADDR_W;
  localparam int BANK_DEPTH  = 1 << BANK_ADDR_W;

  // Value loaded into every word and the output register on reset
  localparam logic [RAM_DATA_W-1:0] RAM_RESET_WORD = 16'h0000;

  // Upper address bits select which bank holds the word
  function automatic logic [BANK_SEL_W-1:0] bank_sel(input logic [RAM_ADDR_W-1:0] addr);
    return addr[RAM_ADDR_W-1:BANK_ADDR_W];
  endfunction

  // Lower address bits locate the word inside its bank
  function automatic logic [BANK_ADDR_W-1:0] bank_offset(input logic [RAM_ADDR_W-1:0] addr);
    return addr[BANK_ADDR_W-1:0];
  endfunction

endpackage : mem_pkg

// File: rtl/ram512.sv
// -----------------------------------------------------------------------------
// ram512
// One 512 x 16 bank of the main data store. Writes are synchronous. The read
// path is purely combinational so the parent can mux the eight banks and
// register the result exactly once.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high; clears every word
//   addr     in   9   word offset within the bank
//   data_in  in  16   write data
//   we       in   1   write enable (already qualified by bank select)
//   rd_data  out 16   combinational read of mem[addr]
// -----------------------------------------------------------------------------
module ram512
  import mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BANK_ADDR_W-1:0] addr,
  input  logic [RAM_DATA_W-1:0]  data_in,
  input  logic                   we,
  output logic [RAM_DATA_W-1:0]  rd_data
);

  logic [RAM_DATA_W-1:0] mem_r [BANK_DEPTH];

  // Storage array: reset clears all words, otherwise commit an enabled write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        mem_r[i] <= RAM_RESET_WORD;
      end
    end else if (we) begin
      mem_r[addr] <= data_in;
    end
  end

  // Asynchronous read; the registering happens once, at the top level
  assign rd_data = mem_r[addr];

endmodule : ram512

// File: rtl/ram_4k.sv
// -----------------------------------------------------------------------------
// ram_4k
// Single-port 4096 x 16 RAM: the main data store of the 16-bit datapath.
// Built from eight ram512 banks. One word address per cycle; writes are
// synchronous and the read port is registered with one cycle of latency.
// A write also loads the written word into data_out (write-first).
//
// Ports
//   clk       in   1   single rising-edge clock
//   reset     in   1   synchronous active-high; clears array and data_out
//   addr      in  12   word address 0x000..0xFFF (read and write)
//   data_in   in  16   write data
//   we        in   1   write enable, active-high
//   data_out  out 16   registered read data
// -----------------------------------------------------------------------------
module ram_4k
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [RAM_DATA_W-1:0] data_in,
  input  logic                  we,
  output logic [RAM_DATA_W-1:0] data_out
);

  logic [BANK_SEL_W-1:0]  bank_sel_s;
  logic [BANK_ADDR_W-1:0] bank_off_s;
  logic [NUM_BANKS-1:0]   bank_we_s;
  logic [RAM_DATA_W-1:0]  bank_rd_s [NUM_BANKS];
  logic [RAM_DATA_W-1:0]  rd_mux_s;
  logic [RAM_DATA_W-1:0]  data_out_r;

  assign bank_sel_s = bank_sel(addr);
  assign bank_off_s = bank_offset(addr);

  // Each bank sees the shared offset, write data and reset; only the
  // selected bank receives the write enable, so no two addresses alias.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign bank_we_s[g] = we & (bank_sel_s == BANK_SEL_W'(g));

    ram512 u_ram512 (
      .clk     (clk),
      .reset   (reset),
      .addr    (bank_off_s),
      .data_in (data_in),
      .we      (bank_we_s[g]),
      .rd_data (bank_rd_s[g])
    );
  end

  // 8:1 read mux on the bank select bits
  always_comb begin
    rd_mux_s = RAM_RESET_WORD;
    case (bank_sel_s)
      3'd0:    rd_mux_s = bank_rd_s[0];
      3'd1:    rd_mux_s = bank_rd_s[1];
      3'd2:    rd_mux_s = bank_rd_s[2];
      3'd3:    rd_mux_s = bank_rd_s[3];
      3'd4:    rd_mux_s = bank_rd_s[4];
      3'd5:    rd_mux_s = bank_rd_s[5];
      3'd6:    rd_mux_s = bank_rd_s[6];
      3'd7:    rd_mux_s = bank_rd_s[7];
      default: rd_mux_s = RAM_RESET_WORD;
    endcase
  end

  // Output register: reset wins, then a write bypasses data_in, else read
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= RAM_RESET_WORD;
    end else if (we) begin
      data_out_r <= data_in;
    end else begin
      data_out_r <= rd_mux_s;
    end
  end

  assign data_out = data_out_r;

endmodule : ram_4k

// File: tb/tb_ram_4k.sv
// -----------------------------------------------------------------------------
// tb_ram_4k
// Self-checking bench for ram_4k. Each operation is driven at the falling
// edge; the expected data_out is pushed to a scoreboard queue and popped
// after the following rising edge for comparison. A reference array tracks
// memory contents for the randomised phase.
// -----------------------------------------------------------------------------
module tb_ram_4k;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic [15:0] data_in;
  logic        we;
  logic [15:0] data_out;

  always #5 clk = ~clk;

  ram_4k dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
  );

  logic [15:0] model [4096];
  logic [15:0] exp_q [$];
  string       tag_q [$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive one operation, record the expected output, update the reference
  // array, then pop and compare once the edge has passed.
  task automatic op(input string tag, input logic r, input logic w,
                    input logic [11:0] a, input logic [15:0] d,
                    input logic [15:0] exp);
    @(negedge clk);
    reset   = r;
    we      = w;
    addr    = a;
    data_in = d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (r) begin
      for (int i = 0; i < 4096; i++) model[i] = 16'h0000;
    end else if (w) begin
      model[a] = d;
    end
    @(posedge clk);
    #1;
    check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  // Randomised operation with its expectation derived from the reference array
  task automatic rand_op(input int n);
    logic [11:0] a;
    logic [15:0] d;
    logic        w;
    logic        r;
    int          pick;
    pick = $urandom_range(0, 9);
    case (pick)
      0:       a = 12'h000;
      1:       a = 12'hFFF;
      2:       a = 12'h1FF;
      3:       a = 12'h200;
      default: a = 12'($urandom_range(0, 4095));
    endcase
    d = 16'($urandom());
    w = ($urandom_range(0, 1) == 1);
    r = ($urandom_range(0, 99) < 2);
    if (r)      op($sformatf("rnd%0d_rst", n), 1'b1, w, a, d, 16'h0000);
    else if (w) op($sformatf("rnd%0d_wr", n), 1'b0, 1'b1, a, d, d);
    else        op($sformatf("rnd%0d_rd", n), 1'b0, 1'b0, a, d, model[a]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    we      = 1'b0;
    addr    = 12'h000;
    data_in = 16'h0000;

    // Reset then read
    op("reset",        1'b1, 1'b0, 12'h000, 16'h0000, 16'h0000);
    op("rst_rd_000",   1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000);
    op("rst_rd_001",   1'b0, 1'b0, 12'h001, 16'h0000, 16'h0000);
    op("rst_rd_fff",   1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h0000);

    // Write / read address 0
    op("wr_000",       1'b0, 1'b1, 12'h000, 16'hAAAA, 16'hAAAA);
    op("rd_000",       1'b0, 1'b0, 12'h000, 16'h0000, 16'hAAAA);

    // Multiple addresses
    op("wr_001",       1'b0, 1'b1, 12'h001, 16'hF0F0, 16'hF0F0);
    op("wr_0ff",       1'b0, 1'b1, 12'h0FF, 16'h5555, 16'h5555);
    op("rd_000_b",     1'b0, 1'b0, 12'h000, 16'h0000, 16'hAAAA);
    op("rd_001",       1'b0, 1'b0, 12'h001, 16'h0000, 16'hF0F0);
    op("rd_0ff",       1'b0, 1'b0, 12'h0FF, 16'h0000, 16'h5555);

    // data_out must not follow addr between edges
    @(negedge clk);
    addr = 12'h000;
    #2;
    check_eq("hold_no_comb", data_out, 16'h5555);

    // Bank boundaries and aliasing
    op("wr_1ff",       1'b0, 1'b1, 12'h1FF, 16'h1234, 16'h1234);
    op("wr_200",       1'b0, 1'b1, 12'h200, 16'hABCD, 16'hABCD);
    op("wr_fff",       1'b0, 1'b1, 12'hFFF, 16'hBEEF, 16'hBEEF);
    op("rd_1ff",       1'b0, 1'b0, 12'h1FF, 16'h0000, 16'h1234);
    op("rd_200",       1'b0, 1'b0, 12'h200, 16'h0000, 16'hABCD);
    op("rd_fff",       1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF);
    op("rd_000_c",     1'b0, 1'b0, 12'h000, 16'h0000, 16'hAAAA);
    op("rd_1ff_b",     1'b0, 1'b0, 12'h1FF, 16'h0000, 16'h1234);
    op("rd_dff_alias", 1'b0, 1'b0, 12'hDFF, 16'h0000, 16'h0000);
    op("rd_e00_alias", 1'b0, 1'b0, 12'hE00, 16'h0000, 16'h0000);

    // Write-first and overwrite
    op("wr_010_1",     1'b0, 1'b1, 12'h010, 16'h0001, 16'h0001);
    op("wr_010_2",     1'b0, 1'b1, 12'h010, 16'h0002, 16'h0002);
    op("rd_010",       1'b0, 1'b0, 12'h010, 16'h0000, 16'h0002);

    // Reset mid-operation discards the concurrent write and clears everything
    op("rst_with_wr",  1'b1, 1'b1, 12'h020, 16'h7777, 16'h0000);
    op("rd_020_rst",   1'b0, 1'b0, 12'h020, 16'h0000, 16'h0000);
    op("rd_000_rst",   1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000);
    op("rd_200_rst",   1'b0, 1'b0, 12'h200, 16'h0000, 16'h0000);
    op("rd_fff_rst",   1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h0000);

    // Randomised traffic across the whole address space
    for (int n = 0; n < 400; n++) begin
      rand_op(n);
    end

    // Every bank at its first and last offset after the random mix
    for (int b = 0; b < 8; b++) begin
      logic [11:0] lo;
      logic [11:0] hi;
      lo = 12'(b * 512);
      hi = 12'(b * 512 + 511);
      op($sformatf("sweep_wr_lo%0d", b), 1'b0, 1'b1, lo, 16'(16'hC000 + b), 16'(16'hC000 + b));
      op($sformatf("sweep_wr_hi%0d", b), 1'b0, 1'b1, hi, 16'(16'hD000 + b), 16'(16'hD000 + b));
    end
    for (int b = 0; b < 8; b++) begin
      logic [11:0] lo;
      logic [11:0] hi;
      lo = 12'(b * 512);
      hi = 12'(b * 512 + 511);
      op($sformatf("sweep_rd_lo%0d", b), 1'b0, 1'b0, lo, 16'h0000, 16'(16'hC000 + b));
      op($sformatf("sweep_rd_hi%0d", b), 1'b0, 1'b0, hi, 16'h0000, 16'(16'hD000 + b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_4k
